// File: rtl/prim_timer_pkg.sv
// Shared types and defaults for the prim_timer_cmp timer slice.
// The optional prescaler is enabled with PRIM_TIMER_CMP_PRESCALER_EN.
package prim_timer_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 32;
  localparam int unsigned PSC_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } timer_state_e;

  function automatic logic state_is_busy(timer_state_e s);
    return (s == ARM) || (s == RUN);
  endfunction

endpackage

// File: rtl/prim_prescaler.sv
// Cycle divider: o_tick pulses for one cycle every (i_div+1) enabled cycles.
// Only instantiated when PRIM_TIMER_CMP_PRESCALER_EN is defined.
module prim_prescaler #(
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [PSC_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [PSC_WIDTH-1:0] cnt_q;

  assign o_tick = i_en & (cnt_q == i_div);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= o_tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prim_timer_cmp.sv
// Compare/control stage turning an external up counter into a reloadable timer.
// Define PRIM_TIMER_CMP_PRESCALER_EN to gate counting through prim_prescaler.
module prim_timer_cmp
  import prim_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned PSC_WIDTH = PSC_WIDTH_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_cfg_we,
  input  logic [WIDTH-1:0]     i_cmp_val,
  input  logic [WIDTH-1:0]     i_reload_val,
  input  logic                 i_periodic,
  input  logic [PSC_WIDTH-1:0] i_psc_div,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_irq_clr,
  input  logic [WIDTH-1:0]     i_count,
  output logic                 o_cnt_en,
  output logic                 o_cnt_load,
  output logic [WIDTH-1:0]     o_cnt_load_data,
  output logic                 o_irq,
  output logic                 o_busy
);

  timer_state_e     state_q;
  timer_state_e     state_d;
  logic [WIDTH-1:0] cmp_q;
  logic [WIDTH-1:0] reload_q;
  logic             periodic_q;
  logic             irq_q;
  logic             tick;
  logic             match;
  logic             cfg_ok;

  // Configuration is frozen while the counter is owned by the timer.
  assign cfg_ok = i_cfg_we & ((state_q == IDLE) | (state_q == DONE));

`ifdef PRIM_TIMER_CMP_PRESCALER_EN
  logic [PSC_WIDTH-1:0] psc_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      psc_q <= '0;
    end else if (cfg_ok) begin
      psc_q <= i_psc_div;
    end
  end

  prim_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  ((state_q == ARM) | i_stop),
    .i_en   (state_q == RUN),
    .i_div  (psc_q),
    .o_tick (tick)
  );
`else
  logic unused_psc_div;

  assign unused_psc_div = ^i_psc_div;
  assign tick           = 1'b1;
`endif

  assign match = (state_q == RUN) & tick & (i_count == cmp_q);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cmp_q      <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
    end else if (cfg_ok) begin
      cmp_q      <= i_cmp_val;
      reload_q   <= i_reload_val;
      periodic_q <= i_periodic;
    end
  end

  // A new match wins over a clear arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      irq_q <= 1'b0;
    end else if (match) begin
      irq_q <= 1'b1;
    end else if (i_irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = ARM;
        ARM:     state_d = RUN;
        RUN:     if (match && !periodic_q) state_d = DONE;
        DONE:    if (i_start) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // On a periodic match the reload replaces the increment outright.
  always_comb begin
    o_cnt_en   = 1'b0;
    o_cnt_load = 1'b0;
    if (!i_stop) begin
      case (state_q)
        ARM: o_cnt_load = 1'b1;
        RUN: begin
          if (match) begin
            o_cnt_load = periodic_q;
          end else begin
            o_cnt_en = tick;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt_load_data = reload_q;
  assign o_irq           = irq_q;
  assign o_busy          = state_is_busy(state_q);

endmodule

// File: doc/prim_timer_cmp.md
# prim_timer_cmp

Compare-and-control stage that drives a free-running up counter's enable and synchronous-load inputs and consumes its count output. It turns a plain up counter into a programmable timer: it loads a reload value, gates counting through an optional prescaler, detects a match against a compare value, reloads or stops, and raises a sticky interrupt. It sits directly downstream of the counter's `o_count` and upstream of its `i_en`, `i_load` and `i_load_data`.

## Interface
- `WIDTH`, 32, counter/compare width
- `PSC_WIDTH`, 8, prescaler divisor width
- `i_clk`  in  1  clock
- `i_rstn`  in  1  asynchronous, active-low reset
- `i_cfg_we`  in  1  capture `i_cmp_val`, `i_reload_val`, `i_periodic`, `i_psc_div`
- `i_cmp_val`  in  WIDTH  compare value
- `i_reload_val`  in  WIDTH  value loaded into the counter at start and on periodic match
- `i_periodic`  in  1  1 = auto-reload, 0 = one-shot
- `i_psc_div`  in  PSC_WIDTH  prescaler divisor; tick every `i_psc_div+1` cycles
- `i_start`  in  1  start pulse
- `i_stop`  in  1  stop pulse
- `i_irq_clr`  in  1  clear the pending interrupt
- `i_count`  in  WIDTH  count from the counter
- `o_cnt_en`  out  1  counter enable
- `o_cnt_load`  out  1  counter synchronous load
- `o_cnt_load_data`  out  WIDTH  counter load value; always equals the reload register
- `o_irq`  out  1  sticky interrupt pending
- `o_busy`  out  1  state is ARM or RUN

## Operation
- Config registers (`cmp_q`, `reload_q`, `periodic_q`, `psc_q`) are written on `i_cfg_we` only in IDLE or DONE. The write is ignored in ARM and RUN.
- FSM states: IDLE, ARM, RUN, DONE.
  - IDLE: counter frozen. `i_start` moves to ARM.
  - ARM: one cycle. `o_cnt_load=1`, prescaler cleared. Next state is RUN.
  - RUN: `o_cnt_en = tick`.
  - DONE: counter frozen and holds its value. `i_start` moves to ARM; `i_stop` moves to IDLE.
- Match is combinational: `match = (state==RUN) & tick & (i_count==cmp_q)`.
- On match in periodic mode: `o_cnt_load=1` in the same cycle, and load overrides enable. State stays RUN.
- On match in one-shot mode: `o_cnt_en=0` in the same cycle. Next state is DONE.
- Priority: `i_stop` > match > `i_start`.
  - `i_stop` in ARM or RUN forces `o_cnt_en=0` and `o_cnt_load=0` combinationally in that cycle. Next state is IDLE.
  - `i_start` in RUN is ignored.
- Interrupt: on match the pending bit is set; `i_irq_clr` clears it. If set and clear occur in the same cycle, set wins.
- Wrap-around: compare is modulo 2^WIDTH. With `cmp < reload`, the counter wraps through 0 and the period is `(cmp - reload + 1) mod 2^WIDTH` ticks. With `cmp == reload`, a match occurs on every tick.
- Reset values: state=IDLE; `cmp_q`, `reload_q`, `psc_q` = 0; `periodic_q` = 0; `o_irq` = 0; `o_cnt_en` = 0; `o_cnt_load` = 0; `o_busy` = 0.
- Reset mid-operation returns the block to IDLE immediately. The counter is reset independently.

## Timing
- `o_cnt_en`, `o_cnt_load` and `o_cnt_load_data` are combinational from the state and registers. The counter updates `i_count` one cycle later.
- The first RUN cycle sees `i_count == reload_q`.
- Period: `(cmp_q - reload_q + 1)` ticks, which is `(psc_q+1)` times as many cycles.
- `o_irq` rises one cycle after the match cycle.
- `o_busy` rises the cycle after `i_start` and falls the cycle after a one-shot match or `i_stop`.
- Start to first increment: the ARM cycle, then the first tick in RUN.

## Configuration
- Macro `PRIM_TIMER_CMP_PRESCALER_EN`.
- Defined: `prim_prescaler` is instantiated. `tick` pulses when the prescaler count equals `psc_q`. The prescaler count clears in ARM and on `i_stop`.
- Undefined: `tick` is constant 1. `i_psc_div` is present but ignored. `psc_q` and the prescaler logic are removed.

## Structure
- Package `prim_timer_pkg`:
  - `timer_state_e` enum: IDLE, ARM, RUN, DONE, 2-bit.
  - Localparam for the default `PSC_WIDTH`.
- Sub-module `prim_prescaler`:
  - Inputs: clock, reset, clear, enable, divisor.
  - Output: a single-cycle `o_tick`.
  - Instantiated only under the macro.

## Test plan
- Periodic, `psc=0`, `reload=0`, `cmp=3`, start: count goes 0,1,2,3,0,1…; `o_cnt_load` pulses every 4 cycles; `o_irq` rises the cycle after the first match; `i_irq_clr` clears it.
- One-shot, `reload=5`, `cmp=7`: count stops at 7, FSM reaches DONE, `o_busy=0`. A new `i_start` reloads 5 and runs again.
- Wrap-around, `WIDTH=8`, `reload=0xFE`, `cmp=0x01`, periodic: sequence FE,FF,00,01,FE; period is 4 ticks.
- Prescaler (macro on), `psc_div=2`, `reload=0`, `cmp=1`: counter increments every 3 cycles; match occurs every 6 cycles.
- Simultaneous events:
  - `i_stop` with match: IDLE, no load.
  - Match with `i_irq_clr`: `o_irq` stays 1.
  - `i_cfg_we` in RUN: registers unchanged.
- Reset asserted in RUN: all outputs are 0 asynchronously and state is IDLE. After release, counting does not start until `i_start`.
